// File: rtl/demux_1x4_deser.sv
// 1:4 lane deserializer: scatters narrow beats into a 4-lane word with one held output word.
// Optional DEMUX_PARITY_EN adds a fifth parity beat per word and reports out_perr.
module demux_1x4_deser_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module demux_1x4_deser #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sof,
  output logic [2:0]          phase,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic                out_perr,
  output logic                sync_err
);
`ifdef DEMUX_PARITY_EN
  localparam int NSTG = 4;
`else
  localparam int NSTG = 3;
`endif
  // The final slot completes the word; it is lane 3 or the parity beat.
  localparam logic [2:0] LAST = 3'(NSTG);

  logic [NSTG-1:0][DATA_W-1:0] stage;
  logic [4*DATA_W-1:0]         word;
  logic [2:0]                  wr_idx;
  logic                        final_slot, acc, resync, load;

  assign final_slot = (phase == LAST);
  assign in_ready   = !(final_slot && out_valid && !out_ready);
  assign acc        = in_valid && in_ready;
  assign resync     = acc && in_sof && (phase != 3'd0);
  assign load       = acc && final_slot && !in_sof;
  // A resync beat always lands in lane 0; the final slot index has no stage lane.
  assign wr_idx     = resync ? 3'd0 : phase;

  generate
    for (genvar k = 0; k < NSTG; k++) begin : g_lane
      demux_1x4_deser_lane #(.DATA_W(DATA_W)) u_lane (
        .clk (clk),
        .rst (rst),
        .we  (acc && (wr_idx == 3'(k))),
        .d   (in_data),
        .q   (stage[k])
      );
    end
  endgenerate

`ifdef DEMUX_PARITY_EN
  assign word = stage;

  always_ff @(posedge clk) begin
    if (rst)       out_perr <= 1'b0;
    else if (load) out_perr <= ^word ^ in_data[0];
  end
`else
  assign word     = {in_data, stage};
  assign out_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= resync;
      if (acc) begin
        if (resync)          phase <= 3'd1;
        else if (final_slot) phase <= 3'd0;
        else                 phase <= phase + 3'd1;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/demux_1x4_deser.md
# demux_1x4_deser

Receive-side counterpart of the 4:1 lane-select path. It accepts a stream of narrow beats, one lane per beat in lane order 0..3, and scatters each beat into its lane slot to rebuild the full 4-lane word. Completed words are presented on a registered valid/ready output. Input collection overlaps with a held output word, so there is one word of buffering and sustained throughput of one beat per cycle.

## Interface
- DATA_W, 8, width of one lane/beat in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  DATA_W  beat payload
- in_sof  in  1  beat is lane 0 of a new word (resync marker)
- phase  out  3  index of next beat slot: 0–3 lanes, 4 parity (parity only with macro)
- out_valid  out  1  word held
- out_ready  in  1  word consumed when out_valid && out_ready
- out_data  out  4*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- out_perr  out  1  parity error for held word (0 without macro)
- sync_err  out  1  one-cycle pulse: partial word discarded by in_sof

## Operation
- Stage register holds lanes 0–2; the final beat loads out_data directly together with stage.
- Accepted beat at phase p<3 is written to stage lane p, and phase increments.
- Accepted beat at phase 3 (no macro) loads out_data = {in_data, stage[2:0]}, sets out_valid, and sets phase to 0.
- in_ready = 0 only when phase is the final slot and out_valid && !out_ready. Otherwise in_ready = 1.
- Output handshake clears out_valid unless a new word loads in the same cycle, in which case out_valid stays 1 and out_data takes the new word.
- in_sof on an accepted beat:
  - At phase 0: normal.
  - At phase ≠0: partial stage is discarded, the beat is written as lane 0, phase becomes 1, and sync_err pulses next cycle.
  - At the parity slot: same resync behaviour.
- in_sof is ignored while in_ready = 0, because no beat is accepted.
- Stage lanes not yet rewritten keep stale values. They are invisible because out_data loads only on word completion.
- State is phase 0..3 (or 0..4). There is no separate FSM beyond phase plus the out_valid flag.

## Timing
- Reset values: phase=0, out_valid=0, out_data=0, stage=0, out_perr=0, sync_err=0.
- in_ready after reset is 1.
- Latency: out_valid=1 in the cycle after the final beat is accepted.
- Back-to-back words: 4 beats/word (5 with parity) with zero bubbles while out_ready=1.
- Stall: final beat waits with in_ready=0 until out_ready. Lanes 0–2 of the next word are accepted meanwhile.
- in_ready is combinational from phase, out_valid, and out_ready. All other outputs are registered.
- rst mid-word discards stage and any held word in the same cycle. No output handshake is reported.

## Configuration
- DEMUX_PARITY_EN defined:
  - Phase 4 is a parity beat; only in_data[0] is used.
  - Loading occurs on the parity beat: out_data={lane3, stage[2:0]}, with lane 3 staged at phase 3.
  - out_perr = ^out_data ^ parity_bit (even parity, 1 = error), registered with the word.
- DEMUX_PARITY_EN undefined:
  - Phase never reaches 4.
  - out_perr is tied to 0.
  - The word loads on the lane-3 beat.

## Test plan
- After reset, beats 0x11,0x22,0x33,0x44 with out_ready=1:
  - out_valid=1 one cycle after 0x44, out_data=0x44332211.
  - out_valid=0 next cycle.
- Two words sent back-to-back with out_ready=0 until the second word's lane 3:
  - in_ready=0 at phase 3.
  - First word 0x44332211 held stable.
  - Raising out_ready consumes it and loads 0x88776655 in the same cycle, out_valid staying 1.
- Beats 0xAA,0xBB then in_sof with 0x01, followed by 0x02,0x03,0x04:
  - sync_err pulses once.
  - out_data=0x04030201.
- Assert rst while phase=2 and out_valid=1:
  - Next cycle phase=0, out_valid=0, out_data=0.
  - The subsequent word assembles correctly.
- DEMUX_PARITY_EN: beats 0x01,0x00,0x00,0x00 then parity 1 gives out_perr=0; parity 0 gives out_perr=1.
- Continuous in_valid=1, out_ready=1 for 40 beats of an incrementing pattern: 10 words, in_ready never 0.
